// File: rtl/roots_readout.sv
// roots_readout: snapshots a decoder result (roots, iteration count, cycle
// count) on each result_valid rising edge and streams it out as one framed
// valid/ready word stream: header, cycle count, then one word per PU root.
module roots_readout #(
    parameter int CODE_DISTANCE_X = 3,
    parameter int CODE_DISTANCE_Z = 2,
    parameter int OUT_WIDTH       = 32,
    localparam int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    localparam int PU_COUNT           = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    localparam int ADDRESS_WIDTH      = 3 * $clog2(MEASUREMENT_ROUNDS),
    localparam int IDX_W              = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1,
    localparam int ROOTS_W            = ADDRESS_WIDTH * PU_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 result_valid,
    input  logic [ROOTS_W-1:0]   roots,
    input  logic [7:0]           iteration_counter,
    input  logic [31:0]          cycle_counter,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow,
    output logic [15:0]          frames_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_CYC,
        S_ROOT
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_rv_d;
    logic [ROOTS_W-1:0]   r_roots;
    logic [7:0]           r_iter;
    logic [31:0]          r_cycle;
    logic [IDX_W-1:0]     r_index;
    logic                 r_overflow;
    logic [15:0]          r_frames;

    logic                 w_start;
    logic                 w_is_last;
    logic                 w_capture_ok;
    logic                 w_capture;
    logic [31:0]          w_hdr;
    logic [ADDRESS_WIDTH-1:0] w_root;

    assign w_start      = result_valid & ~r_rv_d;
    assign w_is_last    = (r_state == S_ROOT) && (r_index == IDX_W'(PU_COUNT - 1));
    // A new frame may start in the same cycle the last word is accepted,
    // which gives back-to-back frames with no idle bubble.
    assign w_capture_ok = (r_state == S_IDLE) | (w_is_last & out_ready);
    assign w_capture    = w_start & w_capture_ok;
    assign w_hdr        = {8'hA5, r_iter, 16'(PU_COUNT)};

    assign busy        = (r_state != S_IDLE);
    assign overflow    = r_overflow;
    assign frames_sent = r_frames;

    // Select the root address of the current PU from the snapshot.
    always_comb begin
        w_root = '0;
        for (int unsigned i = 0; i < PU_COUNT; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_root = r_roots[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and stream outputs; outputs depend only on state and snapshot,
    // so they hold steady while the sink stalls.
    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_next = S_HDR;
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = OUT_WIDTH'(w_hdr);
                if (out_ready) begin
                    w_next = S_CYC;
                end
            end
            S_CYC: begin
                out_valid = 1'b1;
                out_data  = OUT_WIDTH'(r_cycle);
                if (out_ready) begin
                    w_next = S_ROOT;
                end
            end
            S_ROOT: begin
                out_valid = 1'b1;
                out_last  = w_is_last;
                out_data  = OUT_WIDTH'(w_root);
                if (out_ready && w_is_last) begin
                    w_next = w_capture ? S_HDR : S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Edge detect, snapshot capture, root index, overflow flag and frame counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rv_d     <= 1'b0;
            r_roots    <= '0;
            r_iter     <= '0;
            r_cycle    <= '0;
            r_index    <= '0;
            r_overflow <= 1'b0;
            r_frames   <= '0;
        end else begin
            r_rv_d <= result_valid;
            if (w_capture) begin
                r_roots <= roots;
                r_iter  <= iteration_counter;
                r_cycle <= cycle_counter;
            end
            if (w_start && !w_capture_ok) begin
                r_overflow <= 1'b1;
            end
            if (r_state == S_CYC && out_ready) begin
                r_index <= '0;
            end else if (r_state == S_ROOT && out_ready) begin
                if (w_is_last) begin
                    r_index  <= '0;
                    r_frames <= r_frames + 16'd1;
                end else begin
                    r_index <= r_index + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_roots_readout.sv
// tb_roots_readout: randomized self-checking bench for roots_readout
// (X=3, Z=2: 18 PUs, 6-bit root addresses, 20 words per frame).
module tb_roots_readout;

    localparam int PU = 18;
    localparam int AW = 6;
    localparam int FW = PU + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         result_valid;
    logic [PU*AW-1:0] roots;
    logic [7:0]   iteration_counter;
    logic [31:0]  cycle_counter;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic         overflow;
    logic [15:0]  frames_sent;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state: per-PU root addresses and expected word stream
    logic [AW-1:0] root_arr [PU];
    logic [31:0]   exp_d[$];
    bit            exp_l[$];
    logic [31:0]   got_d[$];
    bit            got_l[$];

    bit          prev_stalled;
    logic [31:0] prev_data;
    logic        prev_last;
    int          stall_err;
    bit          hs_last_now;

    roots_readout #(
        .CODE_DISTANCE_X(3),
        .CODE_DISTANCE_Z(2),
        .OUT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .result_valid(result_valid),
        .roots(roots),
        .iteration_counter(iteration_counter),
        .cycle_counter(cycle_counter),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
        .overflow(overflow),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want earlier", $time);
        $fatal(1);
    end

    // Drive the roots bus from the model's address array.
    task automatic pack_roots();
        for (int i = 0; i < PU; i++) roots[i*AW +: AW] = root_arr[i];
    endtask

    task automatic random_result();
        iteration_counter = 8'($urandom);
        cycle_counter     = $urandom;
        for (int i = 0; i < PU; i++) root_arr[i] = AW'($urandom_range(0, 63));
        pack_roots();
    endtask

    // Expected frame: header, cycle count, then one zero-extended root per PU.
    task automatic push_frame();
        exp_d.push_back({8'hA5, iteration_counter, 16'(PU)});
        exp_l.push_back(1'b0);
        exp_d.push_back(cycle_counter);
        exp_l.push_back(1'b0);
        for (int i = 0; i < PU; i++) begin
            exp_d.push_back({26'd0, root_arr[i]});
            exp_l.push_back(i == PU - 1);
        end
    endtask

    // One cycle at the falling edge: choose out_ready, record the word that
    // will be accepted at the next rising edge, note stall violations.
    task automatic tick(input int pct);
        @(negedge clk);
        out_ready   = ($urandom_range(0, 99) < pct);
        hs_last_now = 1'b0;
        if (out_valid) begin
            if (prev_stalled && (out_data !== prev_data || out_last !== prev_last)) stall_err++;
            if (out_ready) begin
                got_d.push_back(out_data);
                got_l.push_back(out_last);
                hs_last_now = out_last;
            end
            prev_stalled = !out_ready;
            prev_data    = out_data;
            prev_last    = out_last;
        end else begin
            if (prev_stalled) stall_err++;
            prev_stalled = 1'b0;
        end
    endtask

    task automatic drain(input int pct, input int n, output bit timed_out);
        int b;
        b = 0;
        while (got_d.size() < n && b < 500) begin
            tick(pct);
            b++;
        end
        timed_out = (got_d.size() < n);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        result_valid = 1'b0;
        out_ready    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
        prev_stalled = 1'b0;
        stall_err    = 0;
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        result_valid      = 1'b0;
        out_ready         = 1'b1;
        roots             = '0;
        iteration_counter = '0;
        cycle_counter     = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, out_last, busy, overflow} !== 4'b0 || out_data !== 32'h0 || frames_sent !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b o=%b d=%h fs=%h, want all zero",
                     out_valid, out_last, busy, overflow, out_data, frames_sent);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got v=%b b=%b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic_frame();
        bit to;
        do_reset();
        iteration_counter = 8'd5;
        cycle_counter     = 32'h1234;
        for (int i = 0; i < PU; i++) root_arr[i] = AW'(i);
        pack_roots();
        push_frame();
        result_valid = 1'b1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_latency_pre: got out_valid=%b, want 0", out_valid);
        end
        tick(100);
        result_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_latency: got v=%b b=%b, want 1 1", out_valid, busy);
        end
        drain(100, FW, to);
        repeat (5) tick(100);
        vectors++;
        if (to || got_d.size() !== FW) begin
            miscompares++;
            $display("FAIL basic_count: got %0d words, want %0d", got_d.size(), FW);
        end
        vectors++;
        if (got_d.size() > 0 && got_d[0] !== 32'hA5050012) begin
            miscompares++;
            $display("FAIL basic_header: got %h, want A5050012", got_d[0]);
        end
        for (int i = 0; i < FW && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL basic_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (frames_sent !== 16'd1 || busy !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_status: got fs=%0d b=%b o=%b, want 1 0 0", frames_sent, busy, overflow);
        end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        random_result();
        push_frame();
        tick(30);
        result_valid = 1'b1;
        tick(30);
        result_valid = 1'b0;
        drain(30, FW, to);
        repeat (5) tick(30);
        vectors++;
        if (to || got_d.size() !== FW) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words, want %0d", got_d.size(), FW);
        end
        for (int i = 0; i < FW && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL bp_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (stall_err !== 0) begin
            miscompares++;
            $display("FAIL bp_stable: got %0d stall violations, want 0", stall_err);
        end
    endtask

    task automatic test_overflow();
        bit to;
        do_reset();
        random_result();
        push_frame();
        result_valid = 1'b1;
        tick(60);
        result_valid = 1'b0;
        drain(60, 10, to);
        random_result();
        result_valid = 1'b1;
        tick(60);
        result_valid = 1'b0;
        drain(60, FW, to);
        repeat (8) tick(100);
        vectors++;
        if (to || got_d.size() !== FW) begin
            miscompares++;
            $display("FAIL ovf_count: got %0d words, want %0d", got_d.size(), FW);
        end
        for (int i = 0; i < FW && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL ovf_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (overflow !== 1'b1 || frames_sent !== 16'd1) begin
            miscompares++;
            $display("FAIL ovf_status: got o=%b fs=%0d, want 1 1", overflow, frames_sent);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        random_result();
        push_frame();
        result_valid = 1'b1;
        for (int k = 0; k < 2 * FW; k++) begin
            tick(100);
            if (k == 0) result_valid = 1'b0;
            if (k == FW - 1) begin
                vectors++;
                if (hs_last_now !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_last_timing: got last=%b at word %0d, want 1", hs_last_now, FW);
                end
                random_result();
                push_frame();
                result_valid = 1'b1;
            end
            if (k == FW) begin
                result_valid = 1'b0;
                vectors++;
                if (out_valid !== 1'b1 || out_data !== exp_d[FW]) begin
                    miscompares++;
                    $display("FAIL b2b_next_hdr: got v=%b d=%h, want 1 %h", out_valid, out_data, exp_d[FW]);
                end
            end
        end
        repeat (5) tick(100);
        vectors++;
        if (got_d.size() !== 2 * FW) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d words, want %0d", got_d.size(), 2 * FW);
        end
        for (int i = 0; i < 2 * FW && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL b2b_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (overflow !== 1'b0 || frames_sent !== 16'd2) begin
            miscompares++;
            $display("FAIL b2b_status: got o=%b fs=%0d, want 0 2", overflow, frames_sent);
        end
    endtask

    task automatic test_roots_change();
        bit to;
        do_reset();
        random_result();
        push_frame();
        result_valid = 1'b1;
        tick(70);
        result_valid = 1'b0;
        drain(70, 5, to);
        roots             = '1;
        iteration_counter = 8'hFF;
        cycle_counter     = 32'hFFFF_FFFF;
        drain(70, FW, to);
        repeat (5) tick(100);
        vectors++;
        if (to || got_d.size() !== FW) begin
            miscompares++;
            $display("FAIL rc_count: got %0d words, want %0d", got_d.size(), FW);
        end
        for (int i = 0; i < FW && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL rc_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        do_reset();
        random_result();
        result_valid = 1'b1;
        drain(100, 7, to);
        reset = 1'b0;
        tick(100);
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || frames_sent !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got v=%b b=%b o=%b fs=%0d, want 0 0 0 0", out_valid, busy, overflow, frames_sent);
        end
        random_result();
        reset = 1'b1;
        exp_d.delete(); exp_l.delete(); got_d.delete(); got_l.delete();
        prev_stalled = 1'b0;
        push_frame();
        drain(100, FW, to);
        repeat (30) tick(100);
        result_valid = 1'b0;
        vectors++;
        if (to || got_d.size() !== FW) begin
            miscompares++;
            $display("FAIL rst_mid_count: got %0d words, want %0d", got_d.size(), FW);
        end
        for (int i = 0; i < FW && i < got_d.size(); i++) begin
            vectors++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                miscompares++;
                $display("FAIL rst_mid_word%0d: got %h last=%b, want %h last=%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        vectors++;
        if (overflow !== 1'b0 || frames_sent !== 16'd1) begin
            miscompares++;
            $display("FAIL rst_mid_status: got o=%b fs=%0d, want 0 1", overflow, frames_sent);
        end
    endtask

    initial begin
        prev_stalled = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        stall_err    = 0;
        hs_last_now  = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_roots_change();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
